sram_arbiter: RTL

- Shares the single 512Kx16 asynchronous SRAM between two requesters: the Amiga-side CPU port and the SPI controller port.
- Both requesters use the toggle handshake. A request is pending while `req != ack`; the arbiter toggles `ack` when the access is complete.
- The block sequences the SRAM strobes with a programmable access width, arbitrates round-robin and returns read data in per-port registers.
- Sits between the bus/SPI front ends and the SRAM pins; clocked by `clk200`.

---
 rtl/sram_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 512Kx16 SRAM between the CPU and SPI ports.
// Each port uses a toggle handshake: a request is pending while req != ack.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic        clk200,
  input  logic        reset_n,
  input  logic        cpu_req,
  output logic        cpu_ack,
  input  logic        cpu_read,
  input  logic [18:0] cpu_address,
  input  logic        cpu_ub,
  input  logic        cpu_lb,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic        spi_req,
  output logic        spi_ack,
  input  logic        spi_read_sram,
  input  logic [18:0] spi_address_sram,
  input  logic        spi_ub,
  input  logic [7:0]  spi_out_sram_in,
  output logic [15:0] spi_in_sram_out,
  output logic [18:0] sram_address,
  input  logic [15:0] sram_data_in,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_spi_q, last_spi_d;  // 1 = SPI was granted most recently
  logic        gnt_spi_q, gnt_spi_d;
  logic        rd_q, rd_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        spi_ack_q, spi_ack_d;
  logic [15:0] cpu_data_q, cpu_data_d;
  logic [15:0] spi_data_q, spi_data_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        busy_q, busy_d;

  logic cpu_pend, spi_pend, take_cpu;

  assign cpu_pend = cpu_req ^ cpu_ack_q;
  assign spi_pend = spi_req ^ spi_ack_q;
  // Ties go to whichever port was not served last.
  assign take_cpu = cpu_pend && (!spi_pend || last_spi_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_spi_d = last_spi_q;
    gnt_spi_d  = gnt_spi_q;
    rd_d       = rd_q;
    cpu_ack_d  = cpu_ack_q;
    spi_ack_d  = spi_ack_q;
    cpu_data_d = cpu_data_q;
    spi_data_d = spi_data_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    doe_d      = doe_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    ub_n_d     = ub_n_q;
    lb_n_d     = lb_n_q;

    unique case (state_q)
      StIdle: begin
        doe_d  = 1'b0;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        ub_n_d = 1'b1;
        lb_n_d = 1'b1;
        if (take_cpu) begin
          gnt_spi_d  = 1'b0;
          last_spi_d = 1'b0;
          rd_d       = cpu_read;
          addr_d     = cpu_address;
          dout_d     = cpu_data_in;
          doe_d      = !cpu_read;
          ub_n_d     = !cpu_ub;
          lb_n_d     = !cpu_lb;
          state_d    = StSetup;
        end else if (spi_pend) begin
          gnt_spi_d  = 1'b1;
          last_spi_d = 1'b1;
          rd_d       = spi_read_sram;
          addr_d     = spi_address_sram;
          dout_d     = {spi_out_sram_in, spi_out_sram_in};
          doe_d      = !spi_read_sram;
          // SPI reads fetch the full word; writes hit a single byte lane.
          ub_n_d     = spi_read_sram ? 1'b0 : !spi_ub;
          lb_n_d     = spi_read_sram ? 1'b0 : spi_ub;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = 4'd0;
        oe_n_d  = !rd_q;
        we_n_d  = rd_q;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = StRecover;
          if (rd_q && gnt_spi_q)  spi_data_d = sram_data_in;
          if (rd_q && !gnt_spi_q) cpu_data_d = sram_data_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRecover: begin
        // Address and write data stay driven through this cycle for hold time.
        if (gnt_spi_q) spi_ack_d = !spi_ack_q;
        else           cpu_ack_d = !cpu_ack_q;
        doe_d   = 1'b0;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      last_spi_q <= 1'b1;
      gnt_spi_q  <= 1'b0;
      rd_q       <= 1'b0;
      cpu_ack_q  <= 1'b0;
      spi_ack_q  <= 1'b0;
      cpu_data_q <= 16'h0;
      spi_data_q <= 16'h0;
      addr_q     <= 19'h0;
      dout_q     <= 16'h0;
      doe_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_spi_q <= last_spi_d;
      gnt_spi_q  <= gnt_spi_d;
      rd_q       <= rd_d;
      cpu_ack_q  <= cpu_ack_d;
      spi_ack_q  <= spi_ack_d;
      cpu_data_q <= cpu_data_d;
      spi_data_q <= spi_data_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      busy_q     <= busy_d;
    end
  end

  assign cpu_ack         = cpu_ack_q;
  assign spi_ack         = spi_ack_q;
  assign cpu_data_out    = cpu_data_q;
  assign spi_in_sram_out = spi_data_q;
  assign sram_address    = addr_q;
  assign sram_data_out   = dout_q;
  assign sram_data_oe    = doe_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_ub_n       = ub_n_q;
  assign sram_lb_n       = lb_n_q;
  assign busy            = busy_q;

endmodule
